reg_file_2r1w: RTL and testbench

REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

---
 rtl/reg_file_2r1w.sv | 93 +++++++++
 tb/tb_reg_file_2r1w.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_2r1w.sv
// rtl/reg_file_2r1w.sv - 2**N x BITS register file, one write port, two registered read ports; REG_FILE_BYPASS_EN selects write-first forwarding
module reg_file_2r1w #(
    parameter int N    = 2,
    parameter int BITS = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            WE,
    input  logic [N-1:0]    address_w,
    input  logic [BITS-1:0] data_w,
    input  logic            CLR,
    input  logic            RE_A,
    input  logic [N-1:0]    address_a,
    input  logic            RE_B,
    input  logic [N-1:0]    address_b,
    output logic [BITS-1:0] data_a,
    output logic [BITS-1:0] data_b,
    output logic            rvalid_a,
    output logic            rvalid_b,
    output logic            wr_a,
    output logic            wr_b
);

    localparam int DEPTH = 1 << N;

    logic [BITS-1:0] mem [DEPTH];
    logic [DEPTH-1:0] valid;

    logic [BITS-1:0] rd_data_a;
    logic [BITS-1:0] rd_data_b;
    logic            rd_valid_a;
    logic            rd_valid_b;

    // Entry storage and valid flags; a write on the same edge as CLR keeps its entry valid
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            valid <= '0;
        end else begin
            if (CLR) begin
                valid <= '0;
            end
            if (WE) begin
                mem[address_w]   <= data_w;
                valid[address_w] <= 1'b1;
            end
        end
    end

    // Read selection from pre-edge state, optionally forwarding the write in progress
    always_comb begin
        rd_data_a  = mem[address_a];
        rd_valid_a = valid[address_a];
        rd_data_b  = mem[address_b];
        rd_valid_b = valid[address_b];
`ifdef REG_FILE_BYPASS_EN
        if (WE && (address_w == address_a)) begin
            rd_data_a  = data_w;
            rd_valid_a = 1'b1;
        end
        if (WE && (address_w == address_b)) begin
            rd_data_b  = data_w;
            rd_valid_b = 1'b1;
        end
`endif
    end

    // Registered read responses; data and flag hold when no request is made
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_a   <= '0;
            data_b   <= '0;
            wr_a     <= 1'b0;
            wr_b     <= 1'b0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
        end else begin
            rvalid_a <= RE_A;
            rvalid_b <= RE_B;
            if (RE_A) begin
                data_a <= rd_data_a;
                wr_a   <= rd_valid_a;
            end
            if (RE_B) begin
                data_b <= rd_data_b;
                wr_b   <= rd_valid_b;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb/tb_reg_file_2r1w.sv - self-checking bench for reg_file_2r1w (N=2/BITS=4 and N=3/BITS=8 side by side)
module tb_reg_file_2r1w;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       we, clr, re_a, re_b;
    logic [2:0] aw, aa, ab;
    logic [7:0] dw;

    logic [3:0] s_data_a, s_data_b;
    logic       s_rvalid_a, s_rvalid_b, s_wr_a, s_wr_b;
    logic [7:0] w_data_a, w_data_b;
    logic       w_rvalid_a, w_rvalid_b, w_wr_a, w_wr_b;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference state per instance: 0 = N2/BITS4, 1 = N3/BITS8
    logic [7:0] m_mem [2][8];
    logic       m_val [2][8];
    logic [7:0] e_da [2];
    logic [7:0] e_db [2];
    logic       e_wa [2];
    logic       e_wb [2];
    logic       e_va [2];
    logic       e_vb [2];

    always #5 clk = ~clk;

    reg_file_2r1w #(.N(2), .BITS(4)) u_s (
        .CLK(clk), .RST(rst), .WE(we), .address_w(aw[1:0]), .data_w(dw[3:0]), .CLR(clr),
        .RE_A(re_a), .address_a(aa[1:0]), .RE_B(re_b), .address_b(ab[1:0]),
        .data_a(s_data_a), .data_b(s_data_b), .rvalid_a(s_rvalid_a), .rvalid_b(s_rvalid_b),
        .wr_a(s_wr_a), .wr_b(s_wr_b)
    );

    reg_file_2r1w #(.N(3), .BITS(8)) u_w (
        .CLK(clk), .RST(rst), .WE(we), .address_w(aw), .data_w(dw), .CLR(clr),
        .RE_A(re_a), .address_a(aa), .RE_B(re_b), .address_b(ab),
        .data_a(w_data_a), .data_b(w_data_b), .rvalid_a(w_rvalid_a), .rvalid_b(w_rvalid_b),
        .wr_a(w_wr_a), .wr_b(w_wr_b)
    );

    task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s[inst%0d]: got %h expected %h at %0t", name, k, act, exp, $time);
    endtask

    function automatic logic [2:0] amask(input int k, input logic [2:0] a);
        return (k == 0) ? {1'b0, a[1:0]} : a;
    endfunction

    function automatic logic [7:0] dmask(input int k, input logic [7:0] d);
        return (k == 0) ? {4'h0, d[3:0]} : d;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                m_mem[k][i] = 8'h00;
                m_val[k][i] = 1'b0;
            end
            e_da[k] = 8'h00; e_db[k] = 8'h00;
            e_wa[k] = 1'b0;  e_wb[k] = 1'b0;
            e_va[k] = 1'b0;  e_vb[k] = 1'b0;
        end
    endtask

    // One clock of stimulus: drive, predict the response from the pre-edge contents, advance the model
    task automatic step(input logic i_we, input logic [2:0] i_aw, input logic [7:0] i_dw, input logic i_clr,
                        input logic i_rea, input logic [2:0] i_aa, input logic i_reb, input logic [2:0] i_ab);
        logic [7:0] nda [2];
        logic [7:0] ndb [2];
        logic       nwa [2];
        logic       nwb [2];
        logic [2:0] wa, ra, rb;
        logic [7:0] d;
        we = i_we; aw = i_aw; dw = i_dw; clr = i_clr;
        re_a = i_rea; aa = i_aa; re_b = i_reb; ab = i_ab;
        for (int k = 0; k < 2; k++) begin
            wa = amask(k, i_aw); d = dmask(k, i_dw);
            ra = amask(k, i_aa); rb = amask(k, i_ab);
            nda[k] = e_da[k]; nwa[k] = e_wa[k];
            ndb[k] = e_db[k]; nwb[k] = e_wb[k];
            if (i_rea) begin
                if (BYPASS && i_we && ra == wa) begin nda[k] = d; nwa[k] = 1'b1; end
                else begin nda[k] = m_mem[k][ra]; nwa[k] = m_val[k][ra]; end
            end
            if (i_reb) begin
                if (BYPASS && i_we && rb == wa) begin ndb[k] = d; nwb[k] = 1'b1; end
                else begin ndb[k] = m_mem[k][rb]; nwb[k] = m_val[k][rb]; end
            end
            if (i_clr) for (int i = 0; i < 8; i++) m_val[k][i] = 1'b0;
            if (i_we) begin m_mem[k][wa] = d; m_val[k][wa] = 1'b1; end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            e_da[k] = nda[k]; e_db[k] = ndb[k];
            e_wa[k] = nwa[k]; e_wb[k] = nwb[k];
            e_va[k] = i_rea;  e_vb[k] = i_reb;
        end
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_da"}, 0, {4'h0, s_data_a}, 8'h00);
        chk({name, "_db"}, 0, {4'h0, s_data_b}, 8'h00);
        chk({name, "_ctl"}, 0, {4'h0, s_rvalid_a, s_rvalid_b, s_wr_a, s_wr_b}, 8'h00);
        chk({name, "_da"}, 1, w_data_a, 8'h00);
        chk({name, "_db"}, 1, w_data_b, 8'h00);
        chk({name, "_ctl"}, 1, {4'h0, w_rvalid_a, w_rvalid_b, w_wr_a, w_wr_b}, 8'h00);
    endtask

    // Compare both instances against the model on every cycle outside reset
    always @(negedge clk) begin
        if (run && !rst) begin
            chk("data_a", 0, {4'h0, s_data_a}, e_da[0]);
            chk("data_b", 0, {4'h0, s_data_b}, e_db[0]);
            chk("wr_a", 0, {7'h0, s_wr_a}, {7'h0, e_wa[0]});
            chk("wr_b", 0, {7'h0, s_wr_b}, {7'h0, e_wb[0]});
            chk("rvalid_a", 0, {7'h0, s_rvalid_a}, {7'h0, e_va[0]});
            chk("rvalid_b", 0, {7'h0, s_rvalid_b}, {7'h0, e_vb[0]});
            chk("data_a", 1, w_data_a, e_da[1]);
            chk("data_b", 1, w_data_b, e_db[1]);
            chk("wr_a", 1, {7'h0, w_wr_a}, {7'h0, e_wa[1]});
            chk("wr_b", 1, {7'h0, w_wr_b}, {7'h0, e_wb[1]});
            chk("rvalid_a", 1, {7'h0, w_rvalid_a}, {7'h0, e_va[1]});
            chk("rvalid_b", 1, {7'h0, w_rvalid_b}, {7'h0, e_vb[1]});
        end
    end

    initial begin
        we = 0; clr = 0; re_a = 0; re_b = 0; aw = 0; aa = 0; ab = 0; dw = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        run = 1'b1;

        // Read of an unwritten entry after reset
        step(0, 3'd0, 8'h00, 0, 1, 3'd2, 0, 3'd0);
        chk("lit_rst_read_da", 0, {4'h0, s_data_a}, 8'h00);
        chk("lit_rst_read_ctl", 0, {6'h0, s_wr_a, s_rvalid_a}, 8'h01);
        idle();

        // Write then read the same entry on both ports
        step(1, 3'd1, 8'h0A, 0, 0, 3'd0, 0, 3'd0);
        step(0, 3'd0, 8'h00, 0, 1, 3'd1, 1, 3'd1);
        chk("lit_dual_read_da", 0, {4'h0, s_data_a}, 8'h0A);
        chk("lit_dual_read_db", 1, w_data_b, 8'h0A);
        chk("lit_dual_read_ctl", 0, {4'h0, s_rvalid_a, s_rvalid_b, s_wr_a, s_wr_b}, 8'h0F);

        // Read of the entry being written in the same cycle
        step(1, 3'd3, 8'h0C, 0, 0, 3'd0, 0, 3'd0);
        step(1, 3'd3, 8'h05, 0, 0, 3'd0, 1, 3'd3);
        chk("lit_same_cycle_db", 0, {4'h0, s_data_b}, BYPASS ? 8'h05 : 8'h0C);
        chk("lit_same_cycle_db", 1, w_data_b, BYPASS ? 8'h05 : 8'h0C);

        // CLR together with a write, then read written and cleared entries
        step(1, 3'd0, 8'h07, 1, 0, 3'd0, 0, 3'd0);
        step(0, 3'd0, 8'h00, 0, 1, 3'd0, 1, 3'd1);
        chk("lit_clr_we_da", 0, {4'h0, s_data_a}, 8'h07);
        chk("lit_clr_we_db", 0, {4'h0, s_data_b}, 8'h0A);
        chk("lit_clr_we_wr", 0, {6'h0, s_wr_a, s_wr_b}, 8'h02);

        // Valid flag sampled before a CLR on the same edge
        step(0, 3'd0, 8'h00, 1, 1, 3'd0, 0, 3'd0);
        chk("lit_clr_read_wr_a", 1, {7'h0, w_wr_a}, 8'h01);
        step(0, 3'd0, 8'h00, 0, 1, 3'd0, 0, 3'd0);
        chk("lit_after_clr_wr_a", 1, {7'h0, w_wr_a}, 8'h00);

        // Reset asserted between request and response
        step(1, 3'd2, 8'h3C, 0, 1, 3'd0, 0, 3'd0);
        we = 0; re_a = 1; aa = 3'd2; re_b = 1; ab = 3'd0;
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        chk_all_zero("async_rst");
        re_a = 0; re_b = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 3'd0, 8'h00, 0, 1, 3'd2, 1, 3'd0);
        chk("lit_post_rst_da", 1, w_data_a, 8'h00);
        idle();

        // Fill all entries with their index, then sweep reads with toggling requests
        for (int i = 0; i < 8; i++) step(1, i[2:0], 8'(i), 0, 0, 3'd0, 0, 3'd0);
        for (int i = 0; i < 16; i++) begin
            logic [2:0] ra, rb;
            ra = 3'(i % 8);
            rb = 3'(7 - (i % 8));
            step(0, 3'd0, 8'h00, 0, (i % 2) == 0, ra, (i % 3) != 0, rb);
            if ((i % 2) == 0) chk("lit_sweep_da", 1, w_data_a, {5'h0, ra});
        end
        idle();
        idle();

        run = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
